// File: rtl/seq_mult_iter_if.sv
// rtl/seq_mult_iter_if.sv - start/busy/done operand and result bundle for seq_mult_iter
interface seq_mult_iter_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/seq_mult_iter.sv
// rtl/seq_mult_iter.sv - iterative radix-2 shift-add multiplier, signed or unsigned per operation
module seq_mult_iter #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   seq_mult_iter_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t               state;
   state_t               state_next;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic                 neg;
   logic                 accept;
   logic                 last;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   result_q;

   // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
   always_comb begin
      mag_a      = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
      mag_b      = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
      accept     = bus.start && ((state == IDLE) || (state == FINISH));
      last       = (count == CW'(WIDTH - 1));
      acc_next   = mplier[0] ? (acc + mcand) : acc;
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last) state_next = FINISH;
         FINISH:  state_next = accept ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         neg      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state  <= state_next;
         busy_q <= (state_next == RUN);
         done_q <= (state_next == FINISH);
         if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
         end else if (state == RUN) begin
            // Multiplicand shifts left while multiplier shifts right: bit count sits at mplier[0].
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last) result_q <= neg ? ('0 - acc_next) : acc_next;
         end
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_seq_mult_iter.sv
// tb/tb_seq_mult_iter.sv - scoreboard testbench for seq_mult_iter
module tb_seq_mult_iter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_mult_iter_if #(.WIDTH(W)) bus ();

   seq_mult_iter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int               checks   = 0;
   int               errors   = 0;
   int               done_cnt = 0;
   logic             prev_done = 1'b0;
   logic [2*W-1:0]   sb[$];

   function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sm);
      logic signed [2*W-1:0] sx;
      logic signed [2*W-1:0] sy;
      if (sm) begin
         sx = {{W{x[W-1]}}, x};
         sy = {{W{y[W-1]}}, y};
         return sx * sy;
      end
      return {{W{1'b0}}, x} * {{W{1'b0}}, y};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return W'(1);
         2: return '1;
         3: return {1'b1, {(W-1){1'b0}}};
         4: return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   // Scoreboard consumer: every done pulse pops one expected product.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         done_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got result %h with empty scoreboard", bus.result);
         end else begin
            logic [2*W-1:0] exp_v;
            exp_v = sb.pop_front();
            if (bus.result !== exp_v) begin
               errors++;
               $display("FAIL scoreboard_result: got %h expected %h", bus.result, exp_v);
            end
         end
         checks++;
         if (prev_done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done high %0d consecutive cycles, expected 1", 2);
         end
      end
      prev_done = bus.done;
   end

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                         input string name);
      int n;
      int busy_n;
      @(negedge clk);
      bus.start = 1'b1; bus.a = x; bus.b = y; bus.signed_mode = sm;
      sb.push_back(model(x, y, sm));
      @(negedge clk);
      bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.signed_mode = ~sm;
      n = 1;
      busy_n = 0;
      while (!bus.done && n < 200) begin
         if (bus.busy) busy_n++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== W + 1) begin
         errors++;
         $display("FAIL %s_latency: done after %0d cycles, expected %0d", name, n, W + 1);
      end
      checks++;
      if (busy_n !== W || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: busy %0d cycles (busy at done=%b), expected %0d", name, busy_n,
                  bus.busy, W);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b result=%h, expected 0 0 0", bus.busy,
                  bus.done, bus.result);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_op(32'd3, 32'd5, 1'b0, "u_3x5");
      checks++;
      if (bus.result !== 64'h0000_0000_0000_000F) begin
         errors++;
         $display("FAIL u_3x5: got %h expected %h", bus.result, 64'hF);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.result !== 64'h0000_0000_0000_000F || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL result_hold: got %h done=%b expected %h done=0", bus.result, bus.done,
                  64'hF);
      end
      run_op(32'hFFFF_FFF9, 32'd6, 1'b1, "s_m7x6");
      checks++;
      if (bus.result !== 64'hFFFF_FFFF_FFFF_FFD6) begin
         errors++;
         $display("FAIL s_m7x6: got %h expected %h", bus.result, 64'hFFFF_FFFF_FFFF_FFD6);
      end
      run_op(32'd6, 32'hFFFF_FFF9, 1'b1, "s_6xm7");
      checks++;
      if (bus.result !== 64'hFFFF_FFFF_FFFF_FFD6) begin
         errors++;
         $display("FAIL s_6xm7: got %h expected %h", bus.result, 64'hFFFF_FFFF_FFFF_FFD6);
      end
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minxmin");
      checks++;
      if (bus.result !== 64'h4000_0000_0000_0000) begin
         errors++;
         $display("FAIL s_minxmin: got %h expected %h", bus.result, 64'h4000_0000_0000_0000);
      end
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_maxxmax");
      checks++;
      if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin
         errors++;
         $display("FAIL u_maxxmax: got %h expected %h", bus.result, 64'hFFFF_FFFE_0000_0001);
      end
      run_op(32'd0, 32'hFFFF_FFFF, 1'b1, "s_zero");
      checks++;
      if (bus.result !== 64'h0) begin
         errors++;
         $display("FAIL s_zero: got %h expected %h", bus.result, 64'h0);
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd5; bus.signed_mode = 1'b0;
      sb.push_back(64'hF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         bus.start = (n == 5);
         bus.a = 32'd100; bus.b = 32'd100; bus.signed_mode = 1'b1;
      end while (!bus.done && n < 200);
      bus.start = 1'b0;
      checks++;
      if (n !== W + 1 || bus.result !== 64'hF) begin
         errors++;
         $display("FAIL start_while_busy: latency %0d result %h, expected %0d %h", n, bus.result,
                  W + 1, 64'hF);
      end
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int second = -1;
      int k = 0;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic sm;
      for (k = 0; k < 150 && second < 0; k++) begin
         @(negedge clk);
         if (bus.done) begin
            if (first < 0) first = k;
            else second = k;
         end
         if (k < 40) begin
            x = W'($urandom); y = W'($urandom); sm = 1'($urandom);
            bus.start = 1'b1; bus.a = x; bus.b = y; bus.signed_mode = sm;
            if (k == 0 || k == W + 1) sb.push_back(model(x, y, sm));
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (first !== W + 1) begin
         errors++;
         $display("FAIL b2b_first_done: at cycle %0d expected %0d", first, W + 1);
      end
      checks++;
      if (second < 0 || (second - first) !== W + 1) begin
         errors++;
         $display("FAIL b2b_spacing: done pulses %0d apart, expected %0d", second - first, W + 1);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd123; bus.b = 32'd456; bus.signed_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b result=%h, expected 0 0 0", bus.busy,
                  bus.done, bus.result);
      end
      rst = 1'b0;
      d0 = done_cnt;
      repeat (45) @(negedge clk);
      checks++;
      if (done_cnt !== d0) begin
         errors++;
         $display("FAIL reset_no_done: %0d done pulses after abort, expected 0", done_cnt - d0);
      end
      run_op(32'd7, 32'd9, 1'b0, "after_reset");
      checks++;
      if (bus.result !== 64'd63) begin
         errors++;
         $display("FAIL after_reset: got %h expected %h", bus.result, 64'd63);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         run_op(pick(), pick(), 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (5) @(negedge clk);
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
